latch_d_behavioral: RTL and testbench



---
 rtl/latch_d_behavioral.sv | 120 ++++++++++++
 tb/tb_latch_d_behavioral.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/latch_d_behavioral.sv
// ----------------------------------------------------------------------------
// latch_d_behavioral
//
// Purpose:
//   Level-sensitive D latch with asynchronous active-low reset, a complemented
//   output, and a clocked sample of the latch output. An optional structural
//   NAND-based gated-D latch can be built alongside the behavioural latch and
//   compared against it every clock.
//
// Parameters:
//   WIDTH     data width of d, q, q_n, q_reg (default 1)
//
// Ports:
//   clk       input          clock; only drives q_reg and the gate-model checker
//   rst_n     input          asynchronous active-low reset
//   d         input  [W-1:0] latch data
//   en        input          active-high transparency enable
//   q         output [W-1:0] latch output
//   q_n       output [W-1:0] bitwise complement of q
//   q_reg     output [W-1:0] q sampled on the rising edge of clk
//   mismatch  output         sticky gate-model disagreement flag
//                            (present only when GATE_MODEL_EN is defined)
//
// Configuration macro:
//   GATE_MODEL_EN  builds the structural NAND latch, the comparator and the
//                  mismatch port. Undefined by default.
//
// Interface timing:
//   There is no handshake. q/q_n respond combinationally to d/en/rst_n while
//   the latch is transparent; q_reg is valid one clk edge after q settles.
// ----------------------------------------------------------------------------
module latch_d_behavioral #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_n,
  output logic [WIDTH-1:0] q_reg
`ifdef GATE_MODEL_EN
  ,
  output logic             mismatch
`endif
);

  // --------------------------------------------------------------------------
  // Behavioural latch. Reset is checked first so it overrides an open enable.
  // The latch never looks at clk, so a stopped clock cannot disturb q.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_latch;

  always_latch begin
    if (!rst_n) begin
      r_latch <= '0;
    end else if (en) begin
      r_latch <= d;
    end
  end

  assign q   = r_latch;
  // Derived straight from the latch so the complement also holds in reset.
  assign q_n = ~r_latch;

  // --------------------------------------------------------------------------
  // Clocked sample of q, one-cycle latency, no enable.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] r_q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_reg <= '0;
    end else begin
      r_q_reg <= r_latch;
    end
  end

  assign q_reg = r_q_reg;

`ifdef GATE_MODEL_EN
  // --------------------------------------------------------------------------
  // Structural gated-D latch, one per bit:
  //   d_n = ~d
  //   s_n = NAND(d,   en, rst_n)     set leg
  //   r_n = NAND(d_n, en)            reset leg
  //   gq  = NAND(s_n, gq_n)
  //   gq_n= NAND(r_n, gq, rst_n)
  // Pulling rst_n low drives s_n high and gq_n high, which forces gq to 0,
  // matching the behavioural reset.
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] w_gm_d_n;
  logic [WIDTH-1:0] w_gm_s_n;
  logic [WIDTH-1:0] w_gm_r_n;
  logic [WIDTH-1:0] w_gm_q;
  logic [WIDTH-1:0] w_gm_q_n;

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gate_bit
    assign w_gm_d_n[gi] = ~d[gi];
    assign w_gm_s_n[gi] = ~(d[gi] & en & rst_n);
    assign w_gm_r_n[gi] = ~(w_gm_d_n[gi] & en);
    assign w_gm_q[gi]   = ~(w_gm_s_n[gi] & w_gm_q_n[gi]);
    assign w_gm_q_n[gi] = ~(w_gm_r_n[gi] & w_gm_q[gi] & rst_n);
  end

  // Sticky: once the two models disagree on a clock edge, stay set until reset.
  logic r_mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mismatch <= 1'b0;
    end else if (w_gm_q != r_latch) begin
      r_mismatch <= 1'b1;
    end
  end

  assign mismatch = r_mismatch;
`endif

endmodule

// File: tb/tb_latch_d_behavioral.sv
// ----------------------------------------------------------------------------
// tb_latch_d_behavioral
//
// Directed vectors for a 1-bit and an 8-bit instance of latch_d_behavioral.
// Drivers change inputs on the falling clk edge; the expected
// {q, q_n, q_reg} is pushed into a queue and a monitor samples 1 ns later,
// well away from the rising edge, and compares.
// ----------------------------------------------------------------------------
module tb_latch_d_behavioral;

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk     = 1'b0;
  logic clk_run = 1'b1;

  always #5 clk = clk_run ? ~clk : clk;

  // 1-bit instance signals
  logic       rst1_n = 1'b0;
  logic       en1    = 1'b0;
  logic [0:0] d1     = '0;
  logic [0:0] q1, q1_n, q1_reg;

  // 8-bit instance signals
  logic       rst8_n = 1'b0;
  logic       en8    = 1'b0;
  logic [7:0] d8     = '0;
  logic [7:0] q8, q8_n, q8_reg;

`ifdef GATE_MODEL_EN
  logic mismatch1;
  logic mismatch8;
`endif

  latch_d_behavioral #(.WIDTH(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst1_n),
    .d        (d1),
    .en       (en1),
    .q        (q1),
    .q_n      (q1_n),
    .q_reg    (q1_reg)
`ifdef GATE_MODEL_EN
    ,
    .mismatch (mismatch1)
`endif
  );

  latch_d_behavioral #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst8_n),
    .d        (d8),
    .en       (en8),
    .q        (q8),
    .q_n      (q8_n),
    .q_reg    (q8_reg)
`ifdef GATE_MODEL_EN
    ,
    .mismatch (mismatch8)
`endif
  );

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  logic [2:0]  exp_q[$];
  logic [23:0] exp8_q[$];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          tag1   = 0;
  int          tag8   = 0;
  event        chk1_ev;
  event        chk8_ev;

  initial begin
    logic [2:0] e;
    logic [2:0] a;
    forever begin
      @(chk1_ev);
      #1;
      a = {q1, q1_n, q1_reg};
      n_vec++;
      if (exp_q.size() == 0) begin
        n_miss++;
        $display("FAIL w1_vec%0d: got q/q_n/q_reg=%b, no expected entry queued", tag1, a);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          n_miss++;
          $display("FAIL w1_vec%0d: got q/q_n/q_reg=%b want %b", tag1, a, e);
        end
      end
      tag1++;
    end
  end

  initial begin
    logic [23:0] e;
    logic [23:0] a;
    forever begin
      @(chk8_ev);
      #1;
      a = {q8, q8_n, q8_reg};
      n_vec++;
      if (exp8_q.size() == 0) begin
        n_miss++;
        $display("FAIL w8_vec%0d: got q/q_n/q_reg=%h, no expected entry queued", tag8, a);
      end else begin
        e = exp8_q.pop_front();
        if (a !== e) begin
          n_miss++;
          $display("FAIL w8_vec%0d: got q/q_n/q_reg=%h want %h", tag8, a, e);
        end
      end
      tag8++;
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks. en is driven before d so that a simultaneous en-fall and
  // d-change presents the closed latch with the new d.
  // --------------------------------------------------------------------------
  task automatic apply1(input logic rst, input logic en, input logic d,
                        input logic eq, input logic eqr);
    en1    = en;
    d1     = d;
    rst1_n = rst;
    exp_q.push_back({eq, ~eq, eqr});
    -> chk1_ev;
  endtask

  task automatic apply8(input logic rst, input logic en, input logic [7:0] d,
                        input logic [7:0] eq, input logic [7:0] eqr);
    en8    = en;
    d8     = d;
    rst8_n = rst;
    exp8_q.push_back({eq, ~eq, eqr});
    -> chk8_ev;
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    // 1-bit: args are rst_n, en, d, expected q, expected q_reg
    @(negedge clk); apply1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); // reset dominates en
    @(negedge clk); apply1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); // release: q=d at once
    @(negedge clk); apply1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1); // q_reg after edge
    @(negedge clk); apply1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); // transparent
    @(negedge clk); apply1(1'b1, 1'b0, 1'b0, 1'b0, 1'b0); // close on 0
    @(negedge clk); apply1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // hold vs d 0->1
    @(negedge clk); apply1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); // transparent d=1
    @(negedge clk); apply1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1); // transparent d=0
    @(negedge clk); apply1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk); apply1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // en fall + d rise together
    @(negedge clk); apply1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // still held
    @(negedge clk); apply1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); // reopen -> 1
    @(negedge clk); apply1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    @(negedge clk); apply1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); // hold a 1
    @(negedge clk); apply1(1'b0, 1'b0, 1'b1, 1'b0, 1'b0); // async reset mid-cycle
    @(negedge clk); apply1(1'b0, 1'b1, 1'b1, 1'b0, 1'b0); // reset over en=1
    @(negedge clk); apply1(1'b1, 1'b0, 1'b1, 1'b0, 1'b0); // release with en=0
    @(negedge clk); apply1(1'b1, 1'b1, 1'b1, 1'b1, 1'b0); // en rises -> d
    @(negedge clk); apply1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1); // hold 1

    // Stop the clock low; the latch must keep working, q_reg must freeze.
    @(negedge clk); apply1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    clk_run = 1'b0;
    #10; apply1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    #10; apply1(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    #10; apply1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #10; apply1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    #10;
    clk_run = 1'b1;

    // 8-bit: args are rst_n, en, d, expected q, expected q_reg
    @(negedge clk); apply8(1'b0, 1'b1, 8'hA5, 8'h00, 8'h00); // reset
    @(negedge clk); apply8(1'b1, 1'b1, 8'hA5, 8'hA5, 8'h00); // transparent
    @(negedge clk); apply8(1'b1, 1'b0, 8'h00, 8'hA5, 8'hA5); // capture A5
    @(negedge clk); apply8(1'b1, 1'b0, 8'h3C, 8'hA5, 8'hA5); // hold
    @(negedge clk); apply8(1'b1, 1'b1, 8'h3C, 8'h3C, 8'hA5); // reopen
    @(negedge clk); apply8(1'b1, 1'b1, 8'hC3, 8'hC3, 8'h3C); // all bits flip
    @(negedge clk); apply8(1'b1, 1'b0, 8'hFF, 8'hC3, 8'hC3); // hold
    @(negedge clk); apply8(1'b0, 1'b1, 8'hFF, 8'h00, 8'h00); // reset

    @(negedge clk);
    #5;

    // Every queued expectation must have been consumed by a monitor.
    n_vec++;
    if (exp_q.size() != 0 || exp8_q.size() != 0) begin
      n_miss++;
      $display("FAIL queue_drain: got %0d/%0d entries left want 0/0",
               exp_q.size(), exp8_q.size());
    end

`ifdef GATE_MODEL_EN
    // Release the 8-bit reset and run a couple of edges before reading the flags.
    rst8_n = 1'b1;
    repeat (2) @(negedge clk);
    n_vec++;
    if (mismatch1 !== 1'b0) begin
      n_miss++;
      $display("FAIL mismatch1: got %b want 0", mismatch1);
    end
    n_vec++;
    if (mismatch8 !== 1'b0) begin
      n_miss++;
      $display("FAIL mismatch8: got %b want 0", mismatch8);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no completion by 100000 ns want completion");
    $fatal(1, "timeout");
  end

endmodule
